// File: rtl/vga_text_buf.sv
// vga_text_buf: character buffer for the text-mode display controller.
// Holds one byte per 8x8 cell and renders a valid/ready character stream
// terminal-style (cursor advance, CR/LF/BS, line wrap).
// Optional macro VGA_TEXT_BUF_SCROLL_EN: hardware scrolling through a
// circular row offset. Without it the cursor wraps from the last row back
// to row 0 and that row is cleared.
module vga_text_buf #(
    parameter int h_disp          = 1280,
    parameter int v_disp          = 1024,
    parameter int char_addr_width = $clog2(h_disp * v_disp / 64)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [7:0]                         in_char,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [char_addr_width-1:0]         addr_read,
    output logic [7:0]                         char_read,
    output logic [$clog2(h_disp/8)-1:0]        cursor_x,
    output logic [$clog2(v_disp/8)-1:0]        cursor_y
);

    localparam int COLS  = h_disp / 8;
    localparam int ROWS  = v_disp / 8;
    localparam int CELLS = ROWS * COLS;
    localparam int AW    = char_addr_width;
    localparam int XW    = $clog2(COLS);
    localparam int YW    = $clog2(ROWS);

    localparam logic [AW:0]   CELLS_W   = (AW+1)'(CELLS);
    localparam logic [AW-1:0] COLS_A    = AW'(COLS);
    localparam logic [AW-1:0] CELL_LAST = AW'(CELLS - 1);
    localparam logic [AW-1:0] COL_LAST  = AW'(COLS - 1);
    localparam logic [XW-1:0] X_LAST    = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(ROWS - 1);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_BS    = 8'h08;

    // Modular add inside the cell space; both operands are below CELLS.
    function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] a,
                                               input logic [AW-1:0] b);
        logic [AW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= CELLS_W)
            s = s - CELLS_W;
        return s[AW-1:0];
    endfunction

    logic [7:0]    mem [CELLS];
    logic [1:0]    state;
    logic [AW-1:0] fill_cnt;   // cell index in INIT, column index in CLEAR
    logic [AW-1:0] row_base;   // physical address of the cursor row start
    logic [AW-1:0] row_next;
    logic [AW-1:0] rd_phys_p0;
    logic [7:0]    rd_data_p1;

    logic          accept;
    logic          is_print;
    logic          wrap_row;
    logic          last_row;
    logic          we;
    logic [AW-1:0] wa;
    logic [7:0]    wd;

`ifdef VGA_TEXT_BUF_SCROLL_EN
    logic [AW-1:0] top_off;    // physical address of screen row 0
    assign rd_phys_p0 = wrap_add(addr_read, top_off);
`else
    assign rd_phys_p0 = addr_read;
`endif

    assign in_ready  = (state == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign is_print  = (in_char >= 8'h20) && (in_char <= 8'h7E);
    assign wrap_row  = accept && ((is_print && (cursor_x == X_LAST)) || (in_char == CH_LF));
    assign last_row  = (cursor_y == Y_LAST);
    // Row bases are multiples of COLS, so stepping past the last row lands on 0.
    assign row_next  = wrap_add(row_base, COLS_A);
    assign char_read = rd_data_p1;

    // Write-port arbitration: fill/clear sweeps or the character at the cursor.
    always_comb begin
        we = 1'b0;
        wa = fill_cnt;
        wd = CH_SPACE;
        case (state)
            ST_INIT: begin
                we = 1'b1;
                wa = fill_cnt;
            end
            ST_CLEAR: begin
                we = 1'b1;
                wa = row_base + fill_cnt;
            end
            ST_IDLE: begin
                if (accept && is_print) begin
                    we = 1'b1;
                    wa = row_base + AW'(cursor_x);
                    wd = in_char;
                end else if (accept && (in_char == CH_BS) && (cursor_x != '0)) begin
                    we = 1'b1;
                    wa = row_base + AW'(cursor_x - 1'b1);
                end
            end
            default: ;
        endcase
    end

    // Control FSM: screen fill, character handling, newline and row clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_INIT;
            fill_cnt <= '0;
            cursor_x <= '0;
            cursor_y <= '0;
            row_base <= '0;
`ifdef VGA_TEXT_BUF_SCROLL_EN
            top_off  <= '0;
`endif
        end else begin
            case (state)
                ST_INIT: begin
                    if (fill_cnt == CELL_LAST) begin
                        state    <= ST_IDLE;
                        fill_cnt <= '0;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (fill_cnt == COL_LAST) begin
                        state    <= ST_IDLE;
                        fill_cnt <= '0;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        if (is_print)
                            cursor_x <= (cursor_x == X_LAST) ? '0 : cursor_x + 1'b1;
                        else if ((in_char == CH_LF) || (in_char == CH_CR))
                            cursor_x <= '0;
                        else if ((in_char == CH_BS) && (cursor_x != '0))
                            cursor_x <= cursor_x - 1'b1;
                    end
                    if (wrap_row) begin
                        row_base <= row_next;
                        if (!last_row) begin
                            cursor_y <= cursor_y + 1'b1;
                        end else begin
`ifdef VGA_TEXT_BUF_SCROLL_EN
                            // The old top row becomes the new bottom row.
                            top_off  <= wrap_add(top_off, COLS_A);
`else
                            cursor_y <= '0;
`endif
                            state    <= ST_CLEAR;
                            fill_cnt <= '0;
                        end
                    end
                end
                default: begin
                    state    <= ST_INIT;
                    fill_cnt <= '0;
                end
            endcase
        end
    end

    // RAM write port.
    always_ff @(posedge clk) begin
        if (we)
            mem[wa] <= wd;
    end

    // Stage p0 -> p1: registered read-first lookup for the display.
    always_ff @(posedge clk) begin
        if (reset)
            rd_data_p1 <= 8'h00;
        else
            rd_data_p1 <= mem[rd_phys_p0];
    end

endmodule

// File: tb/tb_vga_text_buf.sv
// Directed bench for vga_text_buf (default 1280x1024 geometry).
module tb_vga_text_buf;

    localparam int COLS  = 160;
    localparam int ROWS  = 128;
    localparam int CELLS = COLS * ROWS;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_char;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] addr_read;
    logic [7:0]  char_read;
    logic [7:0]  cursor_x;
    logic [6:0]  cursor_y;

    int n_assert = 0;
    int n_fail   = 0;

    vga_text_buf dut (
        .clk       (clk),
        .reset     (reset),
        .in_char   (in_char),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .addr_read (addr_read),
        .char_read (char_read),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int a, output logic [7:0] d);
        addr_read = 15'(a);
        step();
        d = char_read;
    endtask

    task automatic send(input logic [7:0] c);
        in_char  = c;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_ready(input int limit, output int n);
        n = 0;
        while (!in_ready && n < limit) begin
            step();
            n++;
        end
    endtask

    initial begin
        logic [7:0] d;
        int n;
        int drops;
        int bad;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_char   = 8'h00;
        addr_read = '0;
        step();
        step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cursor_x", cursor_x, 0);
        chk("rst_cursor_y", cursor_y, 0);
        chk("rst_char_read", char_read, 8'h00);

        reset = 1'b0;
        wait_ready(30000, n);
        chk("init_cycles", n, CELLS);

        rd(0, d);      chk("init_blank_0", d, 8'h20);
        rd(159, d);    chk("init_blank_159", d, 8'h20);
        rd(10007, d);  chk("init_blank_10007", d, 8'h20);
        rd(20479, d);  chk("init_blank_20479", d, 8'h20);

        send(8'h41);
        send(8'h42);
        chk("ab_cursor_x", cursor_x, 2);
        chk("ab_cursor_y", cursor_y, 0);
        rd(0, d);      chk("ab_addr0", d, 8'h41);
        rd(1, d);      chk("ab_addr1", d, 8'h42);

        send(8'h08);
        rd(1, d);      chk("bs_addr1", d, 8'h20);
        chk("bs_cursor_x", cursor_x, 1);
        send(8'h0D);
        chk("cr_cursor_x", cursor_x, 0);
        send(8'h08);
        chk("bs_col0_cursor_x", cursor_x, 0);
        rd(0, d);      chk("bs_col0_addr0", d, 8'h41);

        // 160 printable bytes back to back: wraps to row 1 with no stall.
        drops    = 0;
        in_char  = 8'h78;
        in_valid = 1'b1;
        for (int i = 0; i < COLS; i++) begin
            if (!in_ready) drops++;
            step();
        end
        in_valid = 1'b0;
        chk("wrap_ready_drops", drops, 0);
        chk("wrap_cursor_x", cursor_x, 0);
        chk("wrap_cursor_y", cursor_y, 1);
        rd(159, d);    chk("wrap_addr159", d, 8'h78);
        rd(0, d);      chk("wrap_addr0", d, 8'h78);

        // Row 1 filled with 'Z', then down to the last row.
        in_char  = 8'h5A;
        in_valid = 1'b1;
        for (int i = 0; i < COLS; i++) step();
        in_valid = 1'b0;
        chk("zrow_cursor_y", cursor_y, 2);
        for (int i = 0; i < 200 && cursor_y != 7'(ROWS - 1); i++) send(8'h0A);
        chk("lf_cursor_y", cursor_y, ROWS - 1);

        send(8'h0A);
        chk("nl_ready_low", in_ready, 0);
        wait_ready(1000, n);
        chk("nl_busy_cycles", n, COLS);
        chk("nl_cursor_x", cursor_x, 0);
`ifdef VGA_TEXT_BUF_SCROLL_EN
        chk("scroll_cursor_y", cursor_y, ROWS - 1);
        rd(0, d);      chk("scroll_addr0", d, 8'h5A);
        rd(159, d);    chk("scroll_addr159", d, 8'h5A);
        rd(20320, d);  chk("scroll_addr20320", d, 8'h20);
        rd(20479, d);  chk("scroll_addr20479", d, 8'h20);
        send(8'h51);
        rd(20320, d);  chk("scroll_q_addr20320", d, 8'h51);
`else
        chk("noscroll_cursor_y", cursor_y, 0);
        rd(0, d);      chk("noscroll_addr0", d, 8'h20);
        rd(159, d);    chk("noscroll_addr159", d, 8'h20);
        rd(160, d);    chk("noscroll_addr160", d, 8'h5A);
        rd(319, d);    chk("noscroll_addr319", d, 8'h5A);
        send(8'h51);
        rd(0, d);      chk("noscroll_q_addr0", d, 8'h51);
`endif
        chk("q_cursor_x", cursor_x, 1);

        // Reset in the middle of a row clear restarts the full fill.
        for (int i = 0; i < 200 && cursor_y != 7'(ROWS - 1); i++) send(8'h0A);
        chk("pre_abort_cursor_y", cursor_y, ROWS - 1);
        send(8'h0A);
        for (int i = 0; i < 50; i++) step();
        chk("mid_clear_ready", in_ready, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_cursor_x", cursor_x, 0);
        chk("abort_cursor_y", cursor_y, 0);
        wait_ready(30000, n);
        chk("abort_init_cycles", n, CELLS);

        bad = 0;
        for (int i = 0; i < CELLS; i++) begin
            rd(i, d);
            if (d !== 8'h20) bad++;
        end
        chk("abort_sweep_nonblank", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_text_buf.md
# vga_text_buf

Character buffer feeding the text-mode display controller: stores one byte per 8×8 cell of the `h_disp`×`v_disp` screen and serves the controller's `addr_read` → `char_read` lookups. A valid/ready character stream on the write side is rendered terminal-style, with cursor advance, CR/LF/backspace, line wrap and hardware scrolling. Scrolling uses a circular row offset, so scroll cost is one row-clear rather than a full-screen copy.

## Interface
Parameters:
- `h_disp`, 1280, visible width in pixels; `COLS = h_disp/8` (160).
- `v_disp`, 1024, visible height in pixels; `ROWS = v_disp/8` (128).
- `char_addr_width`, `$clog2(h_disp*v_disp/64)` (15), linear cell address width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `in_char`  in  8  character or control byte.
- `in_valid`  in  1  `in_char` is valid.
- `in_ready`  out  1  block accepts `in_char` this cycle.
- `addr_read`  in  `char_addr_width`  linear screen cell, row-major, `row*COLS+col`.
- `char_read`  out  8  cell contents, registered.
- `cursor_x`  out  `$clog2(COLS)`  cursor column.
- `cursor_y`  out  `$clog2(ROWS)`  cursor screen row (0 = top line displayed).

## Operation
- Storage is a `ROWS*COLS` × 8 dual-port RAM. The write port is owned by the FSM; the read port serves the display.
- `top_off` is the physical address of screen row 0, always a multiple of `COLS`, in `[0, ROWS*COLS)`. Reset value is 0.
- Read mapping: `phys = addr_read + top_off`; subtract `ROWS*COLS` if `phys >= ROWS*COLS`. The intermediate sum is computed at `char_addr_width+1` bits.
- Write mapping: the same mapping is applied to `cursor_y*COLS + cursor_x`, maintained incrementally with no multiplier.
- FSM states:
  - INIT: entered on reset. Writes 0x20 to every cell, one per cycle, for `ROWS*COLS` cycles, then goes to IDLE.
  - IDLE: `in_ready`=1. On handshake, processes `in_char` as follows:
    - 0x20–0x7E: write the byte at the cursor, then `cursor_x+1`. If `cursor_x` was `COLS-1`, perform NEWLINE.
    - 0x0A (LF): `cursor_x`=0, then NEWLINE.
    - 0x0D (CR): `cursor_x`=0.
    - 0x08 (BS): if `cursor_x`>0, decrement it and write 0x20 at the new position. At column 0, no-op.
    - Any other byte: consumed, no effect.
  - NEWLINE: if `cursor_y < ROWS-1`, `cursor_y+1` and return to IDLE. Otherwise `top_off += COLS` (wrap to 0 at `ROWS*COLS`), `cursor_y` stays `ROWS-1`, and the FSM goes to CLEAR.
  - CLEAR: writes 0x20 to the `COLS` cells of the new bottom row, one per cycle, then goes to IDLE.
- In INIT and CLEAR, `in_ready`=0.
- Reads are never stalled in any state.
- Read/write to the same physical cell in one cycle: `char_read` returns the old contents.

## Timing
- `char_read` is valid one cycle after `addr_read` (read-first RAM output register). Reset value is 0x00.
- Reset values: `in_ready`=0, `cursor_x`=0, `cursor_y`=0, `top_off`=0, state INIT.
- `in_ready` rises exactly `ROWS*COLS` cycles after reset deasserts (20480 by default).
- Handshake is `in_valid && in_ready`. A written cell is readable from the next cycle.
- A printable or control byte that does not scroll leaves `in_ready` high, so the throughput is 1 char/cycle.
- A scrolling byte drops `in_ready` for exactly `COLS` cycles starting the cycle after acceptance. The `top_off` update and the first clear write happen in that first cycle.
- `reset` asserted mid-INIT or mid-CLEAR aborts the fill and restarts INIT from cell 0 on the next cycle.

## Configuration
- `VGA_TEXT_BUF_SCROLL_EN` defined: scrolling as described above.
- Undefined: `top_off` is held at constant 0 and the read mapping is the identity. NEWLINE from row `ROWS-1` sets `cursor_y`=0, then clears screen row 0 via CLEAR (`COLS` cycles, `in_ready`=0).

## Test plan
- Reset, hold `in_valid`=0: `in_ready` is 0 for 20480 cycles, then 1. Random `addr_read` samples all return 0x20.
- Send 'A', 'B': reading addr 0 gives 0x41 and addr 1 gives 0x42, one cycle after the address is presented; `cursor_x`=2, `cursor_y`=0.
- Send 'A', 'B', 0x08: addr 1 reads 0x20, `cursor_x`=1. Then 0x0D, 0x08: `cursor_x`=0, addr 0 still 0x41.
- Send 160 × 'x': `cursor_x`=0, `cursor_y`=1, addr 159 reads 0x78, `in_ready` never drops.
- With the macro defined, fill row 1 with 'Z', move to row 127, send LF: `in_ready`=0 for exactly 160 cycles. Afterwards addr 0 reads 'Z', addrs 20320–20479 read 0x20, `cursor_y`=127. Repeat without the macro: `cursor_y`=0, row 0 cleared, row 1 unchanged.
- Assert `reset` 50 cycles into a scroll's CLEAR: `in_ready`=0 for another full 20480 cycles, cursor is 0,0, all cells read 0x20.
